// File: rtl/vanilla_exe_bubble_profiler_ctrl.sv
// EXE-bubble profiling controller: counts bubble types over a start/stop window, then drains them over valid/ready.
// Optional saturating counters with sticky overflow flags: define VANILLA_BUBBLE_PROFILER_SATURATE_EN.
module vanilla_exe_bubble_profiler_ctrl #(
  parameter int unsigned num_types_p      = 32,
  parameter int unsigned no_bubble_type_p = 31,
  parameter int unsigned ctr_width_p      = 32,
  parameter int unsigned idx_width_p      = 6
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   stall_all_i,
  input  logic [31:0]            exe_bubble_type_i,
  output logic                   busy_o,
  output logic                   v_o,
  input  logic                   ready_i,
  output logic [idx_width_p-1:0] idx_o,
  output logic [ctr_width_p-1:0] count_o,
  output logic                   ovf_o,
  output logic                   done_o
);

  localparam logic [1:0] idle_s  = 2'd0;
  localparam logic [1:0] count_s = 2'd1;
  localparam logic [1:0] drain_s = 2'd2;
  localparam logic [idx_width_p-1:0] win_idx = idx_width_p'(num_types_p);
  localparam logic [ctr_width_p-1:0] ctr_one = ctr_width_p'(1);

  logic [1:0]             state_r, state_n;
  logic [idx_width_p-1:0] idx_n;
  logic                   clear, count_en, done_n, hs;
  logic [ctr_width_p-1:0] ctr_r [num_types_p];
  logic [ctr_width_p-1:0] ctr_n [num_types_p];
  logic [ctr_width_p-1:0] win_r, win_n, count_n;
`ifdef VANILLA_BUBBLE_PROFILER_SATURATE_EN
  logic [num_types_p-1:0] ovf_r, ovf_n;
  logic                   win_ovf_r, win_ovf_n, ovf_d;
`endif

  assign hs = v_o & ready_i;

  // Next-state and control decode
  always_comb begin
    state_n  = state_r;
    idx_n    = idx_o;
    clear    = 1'b0;
    count_en = 1'b0;
    done_n   = 1'b0;
    case (state_r)
      idle_s: begin
        if (start_i) begin
          state_n = count_s;
          clear   = 1'b1;
        end
      end
      count_s: begin
        if (stop_i) begin
          state_n  = drain_s;
          idx_n    = '0;
          count_en = 1'b1;
        end else if (start_i) begin
          clear = 1'b1;
        end else begin
          count_en = 1'b1;
        end
      end
      drain_s: begin
        if (hs) begin
          if (idx_o == win_idx) begin
            state_n = idle_s;
            done_n  = 1'b1;
          end else begin
            idx_n = idx_o + idx_width_p'(1);
          end
        end
      end
      default: state_n = idle_s;
    endcase
  end

  // Counter update; the stop cycle is still counted
  always_comb begin
    ctr_n = ctr_r;
    win_n = win_r;
`ifdef VANILLA_BUBBLE_PROFILER_SATURATE_EN
    ovf_n     = ovf_r;
    win_ovf_n = win_ovf_r;
`endif
    if (clear) begin
      for (int t = 0; t < int'(num_types_p); t++) ctr_n[t] = '0;
      win_n = '0;
`ifdef VANILLA_BUBBLE_PROFILER_SATURATE_EN
      ovf_n     = '0;
      win_ovf_n = 1'b0;
`endif
    end else if (count_en && !stall_all_i) begin
`ifdef VANILLA_BUBBLE_PROFILER_SATURATE_EN
      if (win_r == '1) win_ovf_n = 1'b1;
      else             win_n     = win_r + ctr_one;
`else
      win_n = win_r + ctr_one;
`endif
      for (int t = 0; t < int'(num_types_p); t++) begin
        if (32'(t) != 32'(no_bubble_type_p) && exe_bubble_type_i == 32'(t)) begin
`ifdef VANILLA_BUBBLE_PROFILER_SATURATE_EN
          if (ctr_r[t] == '1) ovf_n[t] = 1'b1;
          else                ctr_n[t] = ctr_r[t] + ctr_one;
`else
          ctr_n[t] = ctr_r[t] + ctr_one;
`endif
        end
      end
    end
  end

  // Drain entry select, loaded only when the next state presents an entry
  always_comb begin
    count_n = count_o;
`ifdef VANILLA_BUBBLE_PROFILER_SATURATE_EN
    ovf_d = ovf_o;
`endif
    if (state_n == drain_s) begin
      count_n = win_n;
`ifdef VANILLA_BUBBLE_PROFILER_SATURATE_EN
      ovf_d = win_ovf_n;
`endif
      for (int t = 0; t < int'(num_types_p); t++) begin
        if (idx_n == idx_width_p'(t)) begin
          count_n = ctr_n[t];
`ifdef VANILLA_BUBBLE_PROFILER_SATURATE_EN
          ovf_d = ovf_n[t];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= idle_s;
    else            state_r <= state_n;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int t = 0; t < int'(num_types_p); t++) ctr_r[t] <= '0;
      win_r   <= '0;
      idx_o   <= '0;
      count_o <= '0;
      busy_o  <= 1'b0;
      v_o     <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      ctr_r   <= ctr_n;
      win_r   <= win_n;
      idx_o   <= idx_n;
      count_o <= count_n;
      busy_o  <= (state_n != idle_s);
      v_o     <= (state_n == drain_s);
      done_o  <= done_n;
    end
  end

`ifdef VANILLA_BUBBLE_PROFILER_SATURATE_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ovf_r     <= '0;
      win_ovf_r <= 1'b0;
      ovf_o     <= 1'b0;
    end else begin
      ovf_r     <= ovf_n;
      win_ovf_r <= win_ovf_n;
      ovf_o     <= ovf_d;
    end
  end
`else
  assign ovf_o = 1'b0;
`endif

endmodule
